data_mem_ctrl: RTL and testbench
================================

Name: data_mem_ctrl

Overview:
- Parametrised, handshaked successor to the single-cycle byte-addressed data memory.
- Sits between the CPU MEM stage and storage. Accepts one load/store request per transaction over a valid/ready interface and inserts a configurable number of wait states.
- Flags misaligned, out-of-range and illegal-func3 accesses with an error response instead of silently corrupting memory.
- The pipeline stalls on req_ready/rsp_valid.

Parameters:
- ADDR_W, 32: request address width.
- DEPTH, 1024: memory size in bytes; must be a power of 2, at least 4.
- WAIT_CYCLES, 1: wait states between accept and response; legal range 0..15.

Ports:
- clk, input, 1: clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- req_valid, input, 1: request present.
- req_ready, output, 1: block can accept a request.
- req_addr, input, ADDR_W: byte address.
- req_we, input, 1: 1 = store, 0 = load.
- req_func3, input, 3: RISC-V funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
- req_wdata, input, 32: store data, taken from low bytes.
- rsp_valid, output, 1: response present.
- rsp_ready, input, 1: consumer accepts the response.
- rsp_rdata, output, 32: load result; 0 for stores and errors.
- rsp_err, output, 1: access rejected.

Behaviour:
- Interface: one clock clk; reset rst_n is asynchronous, active-low.
- Reset values: state = IDLE, req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, wait counter = 0. The storage array is not cleared by reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid at a clock edge: latch addr/we/func3/wdata and load the counter with WAIT_CYCLES.
  - Next state is WAIT if WAIT_CYCLES > 0, otherwise RESP.
- WAIT:
  - req_ready = 0.
  - Counter decrements each cycle; move to RESP on the edge where the counter reaches 1.
- Access commit:
  - Happens on the edge that enters RESP: the store writes, or the load captures rsp_rdata/rsp_err.
  - Latency from accept edge to rsp_valid high is WAIT_CYCLES + 1 cycles.
- RESP:
  - rsp_valid = 1; rsp_rdata and rsp_err are held stable until rsp_ready.
  - On rsp_valid & rsp_ready, go to IDLE and drop rsp_valid.
  - req_ready = 0, so there is no overlap. Throughput is one transaction per WAIT_CYCLES + 2 cycles minimum.
- Data layout:
  - Little-endian.
  - LB/LH are sign-extended from bit 7/15; LBU/LHU are zero-extended; LW is the full word.
  - SB writes 1 byte, SH writes 2 bytes, SW writes 4 bytes.
- Error conditions (rsp_err = 1, no write, rsp_rdata = 0):
  - Halfword access with addr[0] = 1.
  - Word access with addr[1:0] != 0.
  - addr >= DEPTH, compared over the full ADDR_W bits.
  - Load func3 of 3, 6 or 7.
  - Store func3 > 2.
- Stores with no error: rsp_err = 0, rsp_rdata = 0.
- Inputs are sampled only at the accept edge; changes afterwards have no effect.
- Reset mid-operation: asserting rst_n low in WAIT discards the pending store (memory is untouched). In RESP it drops the response. In all cases the block returns to IDLE asynchronously.
- Response asserted with rsp_ready already high: the handshake completes at the first edge after rsp_valid rises, so the response is visible for exactly 1 cycle.

Decomposition:
- Shared package/defines: F3_LB/LH/LW/LBU/LHU/SB/SH/SW (existing), plus the new state encodings DMC_IDLE/DMC_WAIT/DMC_RESP.
- Sub-module dmem_byte_array:
  - DEPTH bytes of storage.
  - Synchronous write with 4-bit byte enable at a word-aligned index.
  - Combinational 32-bit read at that index.
- The controller computes the byte enables, lane shift, extension and error.

Test Plan:
- Reset then SW addr 0x10 data 0xDEADBEEF, WAIT_CYCLES=1 -> rsp_valid 2 cycles after accept, rsp_err=0. Then LW 0x10 -> rsp_rdata=0xDEADBEEF; LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LHU 0x12 -> 0x0000DEAD.
- SH addr 0x21 data 0x1234 -> rsp_err=1. A following LW 0x20 returns the prior contents unchanged. LW 0x22 -> rsp_err=1, rsp_rdata=0.
- LW addr DEPTH (0x400) -> rsp_err=1. Load with func3=3 -> rsp_err=1.
- WAIT_CYCLES=0 and WAIT_CYCLES=3 builds -> rsp_valid rises 1 and 4 cycles after accept. req_ready is low from accept until the response handshake.
- Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_rdata and rsp_err stay stable, and no new request is accepted despite req_valid=1.
- SW 0x30 data 0xA5A5A5A5, pulse rst_n low during WAIT (WAIT_CYCLES=3) -> outputs reset immediately. A later LW 0x30 returns the old value, proving no write was committed.

Source files
------------

// File: rtl/data_mem_ctrl_pkg.sv
// Shared encodings for the handshaked data-memory controller: funct3 codes,
// FSM states and access-size decoding.
package data_mem_ctrl_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    DMC_IDLE = 2'd0,
    DMC_WAIT = 2'd1,
    DMC_RESP = 2'd2
  } dmc_state_e;

  typedef enum logic [1:0] {
    SzByte = 2'd0,
    SzHalf = 2'd1,
    SzWord = 2'd2,
    SzBad  = 2'd3
  } acc_size_e;

  // Map (we, funct3) to an access width; anything not LB/LH/LW/LBU/LHU or SB/SH/SW is SzBad.
  function automatic acc_size_e f3_size(input logic we, input logic [2:0] func3);
    acc_size_e sz;
    sz = SzBad;
    if (we) begin
      case (func3)
        F3_SB:   sz = SzByte;
        F3_SH:   sz = SzHalf;
        F3_SW:   sz = SzWord;
        default: sz = SzBad;
      endcase
    end else begin
      case (func3)
        F3_LB, F3_LBU: sz = SzByte;
        F3_LH, F3_LHU: sz = SzHalf;
        F3_LW:         sz = SzWord;
        default:       sz = SzBad;
      endcase
    end
    return sz;
  endfunction

endpackage

// File: rtl/dmem_byte_array.sv
// Byte-addressable storage organised as 32-bit words: byte-enabled synchronous
// write and combinational read at a word index. Contents are not reset.
module dmem_byte_array #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned IDX_W = 8
) (
  input  logic             clk_i,
  input  logic [3:0]       be_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o
);

  localparam int unsigned Words = DEPTH / 4;

  logic [31:0] mem_q [Words];

  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 4; b++) begin
      if (be_i[b]) begin
        mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/data_mem_ctrl.sv
// Valid/ready load/store controller in front of dmem_byte_array with a fixed
// number of wait states and error responses for illegal accesses.
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_we,
  input  logic [2:0]        req_func3,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned IdxW = (DEPTH > 4) ? $clog2(DEPTH / 4) : 1;

  dmc_state_e        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [2:0]        func3_q, func3_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  // With zero wait states the commit edge is the accept edge, so the live inputs are used.
  logic              in_idle;
  logic [ADDR_W-1:0] acc_addr;
  logic              acc_we;
  logic [2:0]        acc_func3;
  logic [31:0]       acc_wdata;

  assign in_idle   = (state_q == DMC_IDLE);
  assign acc_addr  = in_idle ? req_addr  : addr_q;
  assign acc_we    = in_idle ? req_we    : we_q;
  assign acc_func3 = in_idle ? req_func3 : func3_q;
  assign acc_wdata = in_idle ? req_wdata : wdata_q;

  acc_size_e   size;
  logic [1:0]  off;
  logic        acc_err;
  logic [31:0] rd_word, shifted, load_val, lane_wdata;
  logic [3:0]  be, mem_be;
  logic        commit;

  always_comb begin
    size    = f3_size(acc_we, acc_func3);
    off     = acc_addr[1:0];
    acc_err = 1'b0;
    if (size == SzBad) acc_err = 1'b1;
    if (acc_addr >= ADDR_W'(DEPTH)) acc_err = 1'b1;
    if ((size == SzHalf) && off[0]) acc_err = 1'b1;
    if ((size == SzWord) && (off != 2'b00)) acc_err = 1'b1;

    shifted  = rd_word >> {off, 3'b000};
    load_val = '0;
    case (acc_func3)
      F3_LB:   load_val = {{24{shifted[7]}}, shifted[7:0]};
      F3_LH:   load_val = {{16{shifted[15]}}, shifted[15:0]};
      F3_LW:   load_val = shifted;
      F3_LBU:  load_val = {24'd0, shifted[7:0]};
      F3_LHU:  load_val = {16'd0, shifted[15:0]};
      default: load_val = '0;
    endcase

    be = 4'b0000;
    case (size)
      SzByte:  be = 4'b0001 << off;
      SzHalf:  be = 4'b0011 << off;
      SzWord:  be = 4'b1111;
      default: be = 4'b0000;
    endcase
    lane_wdata = acc_wdata << {off, 3'b000};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    func3_d = func3_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    case (state_q)
      DMC_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          we_d    = req_we;
          func3_d = req_func3;
          wdata_d = req_wdata;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = (WAIT_CYCLES == 0) ? DMC_RESP : DMC_WAIT;
        end
      end
      DMC_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = DMC_RESP;
      end
      DMC_RESP: begin
        if (rsp_ready) state_d = DMC_IDLE;
      end
      default: state_d = DMC_IDLE;
    endcase

    commit = (state_d == DMC_RESP) && (state_q != DMC_RESP);
    if (commit) begin
      rdata_d = (acc_err || acc_we) ? 32'd0 : load_val;
      err_d   = acc_err;
    end
    mem_be = (commit && acc_we && !acc_err) ? be : 4'b0000;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DMC_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      func3_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      func3_q <= func3_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  dmem_byte_array #(
    .DEPTH (DEPTH),
    .IDX_W (IdxW)
  ) u_array (
    .clk_i   (clk),
    .be_i    (mem_be),
    .idx_i   (IdxW'(acc_addr >> 2)),
    .wdata_i (lane_wdata),
    .rdata_o (rd_word)
  );

  assign req_ready = in_idle;
  assign rsp_valid = (state_q == DMC_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Three controllers (0, 1 and 3 wait states) driven in lockstep and checked every
// cycle against a transaction-level model, plus directed literal expectations.
module tb_data_mem_ctrl;

  localparam int unsigned Depth = 1024;
  localparam int NDut = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic            req_valid, req_we;
  logic [31:0]     req_addr, req_wdata;
  logic [2:0]      req_func3;
  logic [NDut-1:0] req_ready, rsp_valid, rsp_ready, rsp_err;
  logic [31:0]     rsp_rdata [NDut];

  function automatic int wc_of(input int g);
    return (g == 0) ? 0 : (g == 1) ? 1 : 3;
  endfunction

  for (genvar g = 0; g < NDut; g++) begin : g_dut
    data_mem_ctrl #(
      .ADDR_W      (32),
      .DEPTH       (Depth),
      .WAIT_CYCLES ((g == 0) ? 0 : (g == 1) ? 1 : 3)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready[g]),
      .req_addr  (req_addr),
      .req_we    (req_we),
      .req_func3 (req_func3),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid[g]),
      .rsp_ready (rsp_ready[g]),
      .rsp_rdata (rsp_rdata[g]),
      .rsp_err   (rsp_err[g])
    );
  end

  // Transaction-level reference: byte memory per DUT, commit WAIT_CYCLES edges after accept.
  logic [7:0]  mm      [NDut][Depth];
  bit          m_busy  [NDut];
  bit          m_valid [NDut];
  int          m_age   [NDut];
  logic [31:0] m_rdata [NDut];
  logic        m_err   [NDut];
  logic        t_we    [NDut];
  logic [31:0] t_addr  [NDut];
  logic [2:0]  t_f3    [NDut];
  logic [31:0] t_wd    [NDut];

  function automatic int acc_bytes(input logic we, input logic [2:0] f3);
    if (we) return (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : (f3 == 3'd2) ? 4 : 0;
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    logic        cw;
    logic [31:0] ca, cwd, v;
    logic [2:0]  cf;
    bit          dc, e;
    int          sz, base;
    if (!rst_n) begin
      for (int g = 0; g < NDut; g++) begin
        m_busy[g]  <= 1'b0;
        m_valid[g] <= 1'b0;
        m_age[g]   <= 0;
      end
    end else begin
      for (int g = 0; g < NDut; g++) begin
        dc = 1'b0; cw = 1'b0; ca = '0; cf = '0; cwd = '0;
        if (!m_busy[g]) begin
          if (req_valid) begin
            m_busy[g] <= 1'b1;
            m_age[g]  <= 0;
            t_we[g] <= req_we; t_addr[g] <= req_addr; t_f3[g] <= req_func3; t_wd[g] <= req_wdata;
            cw = req_we; ca = req_addr; cf = req_func3; cwd = req_wdata;
            dc = (wc_of(g) == 0);
          end
        end else if (m_valid[g]) begin
          if (rsp_ready[g]) begin
            m_busy[g]  <= 1'b0;
            m_valid[g] <= 1'b0;
          end
        end else begin
          m_age[g] <= m_age[g] + 1;
          cw = t_we[g]; ca = t_addr[g]; cf = t_f3[g]; cwd = t_wd[g];
          dc = (m_age[g] + 1 == wc_of(g));
        end
        if (dc) begin
          sz = acc_bytes(cw, cf);
          e  = (sz == 0);
          if (!e) e = (ca >= Depth) || ((ca % sz) != 0);
          base = int'(ca[9:0]);
          v = '0;
          if (!e && !cw) begin
            for (int i = 0; i < 4; i++) if (i < sz) v[8*i +: 8] = mm[g][base+i];
            if (cf == 3'd0) v = {{24{v[7]}}, v[7:0]};
            else if (cf == 3'd1) v = {{16{v[15]}}, v[15:0]};
          end
          if (!e && cw) begin
            for (int i = 0; i < 4; i++) if (i < sz) mm[g][base+i] <= cwd[8*i +: 8];
          end
          m_valid[g] <= 1'b1;
          m_rdata[g] <= (e || cw) ? 32'd0 : v;
          m_err[g]   <= e;
        end
      end
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    for (int g = 0; g < NDut; g++) begin
      chk($sformatf("req_ready[%0d]", g), 32'(req_ready[g]), 32'(!m_busy[g]));
      chk($sformatf("rsp_valid[%0d]", g), 32'(rsp_valid[g]), 32'(m_valid[g]));
      if (m_valid[g]) begin
        chk($sformatf("rsp_rdata[%0d]", g), rsp_rdata[g], m_rdata[g]);
        chk($sformatf("rsp_err[%0d]", g), 32'(rsp_err[g]), 32'(m_err[g]));
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_all();
  endtask

  int          lat_q      [NDut];
  int          vis_q      [NDut];
  logic [31:0] last_rdata [NDut];
  logic        last_err   [NDut];

  task automatic do_txn(input logic we, input logic [31:0] a, input logic [2:0] f3,
                        input logic [31:0] wd, input bit rnd);
    bit done;
    int c;
    req_valid = 1'b1; req_we = we; req_addr = a; req_func3 = f3; req_wdata = wd;
    for (int g = 0; g < NDut; g++) begin
      rsp_ready[g]  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      lat_q[g]      = 0;
      vis_q[g]      = 0;
      last_rdata[g] = 32'hBADBAD00;
      last_err[g]   = 1'bx;
    end
    tick();
    req_valid = 1'b0;
    req_we = 1'($urandom); req_addr = $urandom; req_func3 = 3'($urandom); req_wdata = $urandom;
    done = 1'b0;
    c = 1;
    while (!done && c <= 60) begin
      for (int g = 0; g < NDut; g++) begin
        if (rsp_valid[g]) begin
          if (lat_q[g] == 0) lat_q[g] = c;
          vis_q[g]++;
          last_rdata[g] = rsp_rdata[g];
          last_err[g]   = rsp_err[g];
        end
      end
      if (&req_ready) begin
        done = 1'b1;
      end else begin
        for (int g = 0; g < NDut; g++) rsp_ready[g] = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        tick();
        c++;
      end
    end
    chk("txn_done", 32'(done), 32'd1);
  endtask

  task automatic lit_all(input string name, input logic [31:0] exp_rdata, input logic exp_err);
    for (int g = 0; g < NDut; g++) begin
      chk($sformatf("%s_rdata[%0d]", name, g), last_rdata[g], exp_rdata);
      chk($sformatf("%s_err[%0d]", name, g), 32'(last_err[g]), 32'(exp_err));
    end
  endtask

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int          exp_lat [NDut];
    logic [31:0] s_rdata [NDut];
    logic        s_err   [NDut];
    logic [31:0] a;
    int          r;
    exp_lat = '{1, 2, 4};
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_func3 = '0;
    rsp_ready = '1;
    repeat (3) @(negedge clk);
    for (int g = 0; g < NDut; g++) begin
      chk($sformatf("rst_req_ready[%0d]", g), 32'(req_ready[g]), 32'd1);
      chk($sformatf("rst_rsp_valid[%0d]", g), 32'(rsp_valid[g]), 32'd0);
      chk($sformatf("rst_rsp_rdata[%0d]", g), rsp_rdata[g], 32'd0);
      chk($sformatf("rst_rsp_err[%0d]", g), 32'(rsp_err[g]), 32'd0);
    end
    rst_n = 1'b1;
    tick();

    for (int w = 0; w < int'(Depth / 4); w++) do_txn(1'b1, 32'(w * 4), 3'd2, $urandom, 1'b1);

    do_txn(1'b1, 32'h10, 3'd2, 32'hDEADBEEF, 1'b0);
    for (int g = 0; g < NDut; g++) begin
      chk($sformatf("latency[%0d]", g), 32'(lat_q[g]), 32'(exp_lat[g]));
      chk($sformatf("visible_cycles[%0d]", g), 32'(vis_q[g]), 32'd1);
    end
    lit_all("sw10", 32'd0, 1'b0);
    do_txn(1'b0, 32'h10, 3'd2, 32'd0, 1'b1); lit_all("lw10", 32'hDEADBEEF, 1'b0);
    do_txn(1'b0, 32'h13, 3'd0, 32'd0, 1'b1); lit_all("lb13", 32'hFFFFFFDE, 1'b0);
    do_txn(1'b0, 32'h13, 3'd4, 32'd0, 1'b1); lit_all("lbu13", 32'h000000DE, 1'b0);
    do_txn(1'b0, 32'h12, 3'd5, 32'd0, 1'b1); lit_all("lhu12", 32'h0000DEAD, 1'b0);
    do_txn(1'b1, 32'h20, 3'd2, 32'hCAFEF00D, 1'b1);
    do_txn(1'b1, 32'h21, 3'd1, 32'h00001234, 1'b1); lit_all("sh21", 32'd0, 1'b1);
    do_txn(1'b0, 32'h20, 3'd2, 32'd0, 1'b1); lit_all("lw20", 32'hCAFEF00D, 1'b0);
    do_txn(1'b0, 32'h22, 3'd2, 32'd0, 1'b1); lit_all("lw22", 32'd0, 1'b1);
    do_txn(1'b0, 32'h400, 3'd2, 32'd0, 1'b1); lit_all("lw400", 32'd0, 1'b1);
    do_txn(1'b0, 32'h10, 3'd3, 32'd0, 1'b1); lit_all("ldf3", 32'd0, 1'b1);
    do_txn(1'b1, 32'h10, 3'd4, 32'h0, 1'b1); lit_all("stf4", 32'd0, 1'b1);
    do_txn(1'b0, 32'h10, 3'd2, 32'd0, 1'b1); lit_all("lw10b", 32'hDEADBEEF, 1'b0);

    // Response back-pressure with a competing request held on the bus
    rsp_ready = '0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_func3 = 3'd2;
    tick();
    req_addr = 32'h20;
    repeat (4) tick();
    for (int g = 0; g < NDut; g++) begin
      s_rdata[g] = rsp_rdata[g];
      s_err[g]   = rsp_err[g];
    end
    repeat (5) tick();
    for (int g = 0; g < NDut; g++) begin
      chk($sformatf("stall_valid[%0d]", g), 32'(rsp_valid[g]), 32'd1);
      chk($sformatf("stall_ready[%0d]", g), 32'(req_ready[g]), 32'd0);
      chk($sformatf("stall_stable_rdata[%0d]", g), rsp_rdata[g], s_rdata[g]);
      chk($sformatf("stall_stable_err[%0d]", g), 32'(rsp_err[g]), 32'(s_err[g]));
      chk($sformatf("stall_rdata[%0d]", g), rsp_rdata[g], 32'hDEADBEEF);
    end
    req_valid = 1'b0;
    rsp_ready = '1;
    tick();
    for (int g = 0; g < NDut; g++) begin
      chk($sformatf("post_stall_ready[%0d]", g), 32'(req_ready[g]), 32'd1);
    end

    // Reset while the 3-wait-state instance still holds an uncommitted store
    do_txn(1'b1, 32'h30, 3'd2, 32'h11223344, 1'b0);
    rsp_ready = '1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h30; req_func3 = 3'd2; req_wdata = 32'hA5A5A5A5;
    tick();
    req_valid = 1'b0;
    tick();
    #1 rst_n = 1'b0;
    #1;
    for (int g = 0; g < NDut; g++) begin
      chk($sformatf("mid_rst_req_ready[%0d]", g), 32'(req_ready[g]), 32'd1);
      chk($sformatf("mid_rst_rsp_valid[%0d]", g), 32'(rsp_valid[g]), 32'd0);
      chk($sformatf("mid_rst_rsp_rdata[%0d]", g), rsp_rdata[g], 32'd0);
      chk($sformatf("mid_rst_rsp_err[%0d]", g), 32'(rsp_err[g]), 32'd0);
    end
    #1 rst_n = 1'b1;
    tick();
    tick();
    do_txn(1'b0, 32'h30, 3'd2, 32'd0, 1'b0);
    chk("rst_lw30[0]", last_rdata[0], 32'hA5A5A5A5);
    chk("rst_lw30[1]", last_rdata[1], 32'hA5A5A5A5);
    chk("rst_lw30[2]", last_rdata[2], 32'h11223344);

    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 9);
      if (r < 4)      a = 32'($urandom_range(0, 1023)) & ~32'h3;
      else if (r < 8) a = 32'($urandom_range(0, 1023));
      else if (r == 8) a = 32'($urandom_range(1024, 1100));
      else            a = $urandom | 32'h8000_0000;
      do_txn(1'($urandom), a, 3'($urandom_range(0, 7)), $urandom, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
